// File: rtl/unified_mem_arbiter_if.sv
// rtl/unified_mem_arbiter_if.sv - CPU fetch/data ports and single-port memory bus of the arbiter
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall_if;
  logic        stall_mem;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    output if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
    output m_req, m_we, m_addr, m_wdata, m_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, stall_if, stall_mem,
    input  m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one memory port between instruction fetch and data access
// Data wins by default; a waiting fetch is forced through after MAX_D_BURST data grants.
module unified_mem_arbiter #(
  parameter int MAX_D_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  unified_mem_arbiter_if.slave  bus
);
  localparam int SW = $clog2(MAX_D_BURST + 1);
  localparam logic [SW-1:0] MAXC = SW'(MAX_D_BURST);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_D = 2'd1;
  localparam logic [1:0] SERVE_I = 2'd2;

  logic [1:0]    r_state;
  logic [SW-1:0] r_starve;
  logic          r_m_req;
  logic          r_m_we;
  logic [31:0]   r_m_addr;
  logic [31:0]   r_m_wdata;
  logic [3:0]    r_m_be;
  logic          r_if_valid;
  logic          r_d_valid;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;

  logic w_done;
  logic w_arb;
  logic w_starved;
  logic w_grant_i;
  logic w_grant_d;

  // Arbitration happens when idle or on the completion edge, so back-to-back grants keep m_req high.
  assign w_done    = r_m_req & bus.m_ready;
  assign w_arb     = (r_state == IDLE) | w_done;
  assign w_starved = (r_starve == MAXC);
  assign w_grant_i = w_arb & bus.if_req & (~bus.d_req | w_starved);
  assign w_grant_d = w_arb & bus.d_req & ~w_grant_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_starve   <= '0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_be     <= '0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;

      if (w_done) begin
        if (r_state == SERVE_D) begin
          r_d_valid <= 1'b1;
          if (!r_m_we) r_d_rdata <= bus.m_rdata;
        end else begin
          r_if_valid <= 1'b1;
          r_if_rdata <= bus.m_rdata;
        end
      end

      if (w_grant_i) begin
        r_state   <= SERVE_I;
        r_m_req   <= 1'b1;
        r_m_we    <= 1'b0;
        r_m_addr  <= bus.if_addr;
        r_m_wdata <= '0;
        r_m_be    <= 4'hF;
      end else if (w_grant_d) begin
        r_state   <= SERVE_D;
        r_m_req   <= 1'b1;
        r_m_we    <= bus.d_we;
        r_m_addr  <= bus.d_addr;
        r_m_wdata <= bus.d_wdata;
        r_m_be    <= bus.d_be;
      end else if (w_arb) begin
        r_state <= IDLE;
        r_m_req <= 1'b0;
      end

      // Starvation only accumulates while a fetch is actually waiting.
      if (!bus.if_req || w_grant_i) begin
        r_starve <= '0;
      end else if (w_grant_d && !w_starved) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  assign bus.m_req     = r_m_req;
  assign bus.m_we      = r_m_we;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_wdata   = r_m_wdata;
  assign bus.m_be      = r_m_be;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.stall_if  = bus.if_req & ~r_if_valid;
  assign bus.stall_mem = bus.d_req & ~r_d_valid;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed bench with a transaction-level model of the arbiter
module tb_unified_mem_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  unified_mem_arbiter_if bus ();

  unified_mem_arbiter #(.MAX_D_BURST(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: the transaction currently owning the memory port, plus expected CPU-side outputs.
  typedef struct packed {
    logic        busy;
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  txn_t        cur;
  int          starve;
  logic        e_iv, e_dv;
  logic [31:0] e_ird, e_drd;
  int          gmask, gcount;
  logic        ifr_now, dr_now;
  logic [31:0] last_rd, d_saved;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cur    = '0;
    starve = 0;
    e_iv   = 1'b0;
    e_dv   = 1'b0;
    e_ird  = '0;
    e_drd  = '0;
  endtask

  task automatic model_edge(input logic ifr, input logic [31:0] ifa, input logic dr,
                            input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                            input logic [3:0] dbe, input logic mr, input logic [31:0] mrd);
    logic finishing;
    int   g;
    finishing = cur.busy && mr;
    g = 0;
    e_iv = 1'b0;
    e_dv = 1'b0;
    if (finishing) begin
      if (cur.is_d) begin
        e_dv = 1'b1;
        if (!cur.we) e_drd = mrd;
      end else begin
        e_iv  = 1'b1;
        e_ird = mrd;
      end
    end
    if (!cur.busy || finishing) begin
      if (ifr && (!dr || starve == MAXB)) begin
        g = 2;
        cur.busy = 1'b1; cur.is_d = 1'b0; cur.we = 1'b0;
        cur.addr = ifa;  cur.wdata = '0;  cur.be = 4'hF;
      end else if (dr) begin
        g = 1;
        cur.busy = 1'b1; cur.is_d = 1'b1; cur.we = dwe;
        cur.addr = da;   cur.wdata = dwd; cur.be = dbe;
      end else begin
        cur.busy = 1'b0;
      end
    end
    if (g != 0) begin
      gmask = (gmask << 1) | ((g == 2) ? 1 : 0);
      gcount++;
    end
    if (!ifr || g == 2) starve = 0;
    else if (g == 1)    starve = (starve + 1 > MAXB) ? MAXB : starve + 1;
  endtask

  task automatic compare_all();
    chk("m_req", bus.m_req, cur.busy);
    if (cur.busy) begin
      chk("m_addr", bus.m_addr, cur.addr);
      chk("m_we", bus.m_we, cur.we);
      if (cur.is_d) begin
        chk("m_wdata", bus.m_wdata, cur.wdata);
        chk("m_be", bus.m_be, cur.be);
      end
    end
    chk("if_valid", bus.if_valid, e_iv);
    chk("d_valid", bus.d_valid, e_dv);
    chk("if_rdata", bus.if_rdata, e_ird);
    chk("d_rdata", bus.d_rdata, e_drd);
    chk("stall_if", bus.stall_if, ifr_now & ~e_iv);
    chk("stall_mem", bus.stall_mem, dr_now & ~e_dv);
  endtask

  // One clock: drive inputs, check the model, advance both DUT and model across the edge.
  task automatic step(input logic ifr, input logic [31:0] ifa, input logic dr, input logic dwe,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                      input logic mr);
    cyc++;
    bus.if_req  = ifr;  bus.if_addr = ifa;
    bus.d_req   = dr;   bus.d_we    = dwe;
    bus.d_addr  = da;   bus.d_wdata = dwd; bus.d_be = dbe;
    bus.m_ready = mr;
    bus.m_rdata = 32'hC0DE_0000 + 32'(cyc);
    last_rd = bus.m_rdata;
    ifr_now = ifr;
    dr_now  = dr;
    #1;
    compare_all();
    @(posedge clk);
    model_edge(ifr, ifa, dr, dwe, da, dwd, dbe, mr, last_rd);
    #1;
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, mr);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0;   bus.d_wdata = '0; bus.d_be = '0;   bus.m_rdata = '0; bus.m_ready = 1'b0;
    ifr_now = 1'b0; dr_now = 1'b0; gmask = 0; gcount = 0; d_saved = '0; last_rd = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_req", bus.m_req, 32'd0);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk("rst_m_be", bus.m_be, 32'd0);
    chk("rst_if_valid", bus.if_valid, 32'd0);
    chk("rst_d_valid", bus.d_valid, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    rst_n = 1'b1;

    // Single fetch with m_ready tied high.
    idle(1, 1'b1);
    step(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("f1_m_req", bus.m_req, 32'd1);
    chk("f1_m_addr", bus.m_addr, 32'h100);
    step(1'b0, 32'h100, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("f1_if_valid", bus.if_valid, 32'd1);
    chk("f1_if_rdata", bus.if_rdata, last_rd);
    chk("f1_m_req_drop", bus.m_req, 32'd0);
    idle(1, 1'b1);
    chk("f1_if_valid_end", bus.if_valid, 32'd0);

    // Simultaneous fetch and data read: data first, fetch next.
    step(1'b1, 32'h300, 1'b1, 1'b0, 32'h2000, '0, 4'hF, 1'b0);
    chk("sim_m_addr_d", bus.m_addr, 32'h2000);
    chk("sim_m_we", bus.m_we, 32'd0);
    chk("sim_stall_if", bus.stall_if, 32'd1);
    step(1'b1, 32'h300, 1'b0, 1'b0, 32'h2000, '0, 4'hF, 1'b1);
    d_saved = last_rd;
    chk("sim_d_valid", bus.d_valid, 32'd1);
    chk("sim_d_rdata", bus.d_rdata, d_saved);
    chk("sim_m_addr_i", bus.m_addr, 32'h300);
    chk("sim_stall_if2", bus.stall_if, 32'd1);
    step(1'b0, 32'h300, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("sim_if_valid", bus.if_valid, 32'd1);
    idle(1, 1'b0);

    // Starvation cap: D,D,D,D,I,D.
    gmask = 0; gcount = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h500, 1'b1, 1'b0, 32'h600, '0, 4'hF, 1'b1);
      chk("burst_m_addr", bus.m_addr, (i == 4) ? 32'h500 : 32'h600);
    end
    chk("burst_model_seq", 32'(gmask), 32'b000010);
    chk("burst_model_cnt", 32'(gcount), 32'd6);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(1, 1'b0);

    // Write with three wait cycles; load data must not change.
    step(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0);
    d_saved = e_drd;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b0);
      chk("wr_m_req", bus.m_req, 32'd1);
      chk("wr_m_addr", bus.m_addr, 32'h40);
      chk("wr_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
      chk("wr_m_be", bus.m_be, 32'hF);
      chk("wr_m_we", bus.m_we, 32'd1);
    end
    step(1'b0, '0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b1);
    chk("wr_d_valid", bus.d_valid, 32'd1);
    chk("wr_d_rdata", bus.d_rdata, d_saved);
    idle(2, 1'b1);

    // Reset while a data read is outstanding.
    step(1'b0, '0, 1'b1, 1'b0, 32'h80, '0, 4'hF, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 32'h80, '0, 4'hF, 1'b0);
    chk("rm_m_req_pre", bus.m_req, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_m_req_async", bus.m_req, 32'd0);
    chk("rm_d_rdata", bus.d_rdata, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    bus.d_req = 1'b0;
    dr_now = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b1);
      chk("rm_no_d_valid", bus.d_valid, 32'd0);
    end

    // Back-to-back fetches.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, '0, '0, '0, 1'b1);
      chk("b2b_m_req", bus.m_req, 32'd1);
      if (i > 0) chk("b2b_if_valid", bus.if_valid, 32'd1);
    end
    step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    chk("b2b_last_valid", bus.if_valid, 32'd1);
    idle(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
